// File: rtl/riscv_defs_pkg.sv
// Shared fetch-side definitions: widths, reset PC, JAL opcode, IFU state encoding.
package riscv_defs;
    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [6:0]  OPCODE_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;
endpackage

// File: rtl/instruction_fetcher_if.sv
// Fetcher bus bundle: memory req/valid handshake, instruction-queue push, redirect.
// master = fetcher side, slave = memory/queue/commit side.
interface instruction_fetcher_if #(parameter int XLEN = riscv_defs::XLEN);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_valid;
    logic [XLEN-1:0] mem_data;
    logic            isq_full;
    logic            instruction_ready;
    logic [XLEN-1:0] instruction_out;
    logic [XLEN-1:0] pc_out;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, instruction_ready, instruction_out, pc_out,
        input  mem_valid, mem_data, isq_full, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instruction_ready, instruction_out, pc_out,
        output mem_valid, mem_data, isq_full, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/jal_imm_gen.sv
// J-type immediate extractor: {imm[20],imm[10:1],imm[11],imm[19:12],0}, sign-extended.
module jal_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    // Scatter the instruction bits back into immediate order; bit 31 is the sign.
    assign imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: holds the PC, fetches words over a level req/valid
// handshake, pushes {word, pc} into the instruction queue with a one-cycle
// strobe while the queue is not full, and restarts on commit-side redirects.
// Optional: IFU_JAL_PREDICT_EN follows JAL targets instead of pc+4.
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC = riscv_defs::RESET_PC_DEF,
    parameter int          XLEN     = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    instruction_fetcher_if.master bus
);
    import riscv_defs::*;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] fetch_next_pc;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

`ifdef IFU_JAL_PREDICT_EN
    logic [XLEN-1:0] jal_imm;

    jal_imm_gen #(.XLEN(XLEN)) u_jal_imm (
        .instr (bus.mem_data[31:0]),
        .imm   (jal_imm)
    );

    // Follow a JAL immediately; anything else falls through sequentially.
    assign fetch_next_pc = (bus.mem_data[6:0] == OPCODE_JAL) ? pc_q + jal_imm
                                                             : pc_q + PC_STEP;
`else
    assign fetch_next_pc = pc_q + PC_STEP;
`endif

    // Next-state and registered-output logic; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        ready_d      = 1'b0;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;

        if (bus.redirect_valid) begin
            pc_d = redirect_aligned;
            unique case (state_q)
                WAIT: begin
                    if (bus.mem_valid) begin
                        // Response lands with the redirect: drop it right here.
                        req_d     = 1'b0;
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        // Memory must still complete the request; eat it later.
                        discard_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.isq_full) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_valid) begin
                        req_d = 1'b0;
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            hold_instr_d = bus.mem_data;
                            hold_pc_d    = pc_q;
                            pc_d         = fetch_next_pc;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Never two pushes back to back: covers the queue's full-flag lag.
                    if (!bus.isq_full && !ready_q) begin
                        ready_d  = 1'b1;
                        instr_d  = hold_instr_q;
                        pc_out_d = hold_pc_q;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; frozen entirely while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            pc_q         <= XLEN'(RESET_PC);
            discard_q    <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            ready_q      <= 1'b0;
            instr_q      <= '0;
            pc_out_q     <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            ready_q      <= ready_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
        end
    end

    assign bus.mem_req           = req_q;
    assign bus.mem_addr          = addr_q;
    assign bus.instruction_ready = ready_q;
    assign bus.instruction_out   = instr_q;
    assign bus.pc_out            = pc_out_q;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: memory model with programmable
// latency, scoreboard of expected pushes compared on every instruction_ready.
module tb_instruction_fetcher;
    import riscv_defs::*;

`ifdef IFU_JAL_PREDICT_EN
    localparam logic [31:0] JAL_NEXT = 32'h0000_0008;
`else
    localparam logic [31:0] JAL_NEXT = 32'h0000_0004;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } push_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b0;

    logic        isq_full_r       = 1'b1;
    logic        redirect_valid_r = 1'b0;
    logic [31:0] redirect_pc_r    = '0;
    logic        mem_valid_r      = 1'b0;
    logic [31:0] mem_data_r       = '0;

    int    tests = 0;
    int    fails = 0;
    int    pulses = 0;
    int    lat = 1;
    int    cnt = 0;
    bit    jal_mode = 1'b0;
    bit    prev_rdy = 1'b0;
    logic  last_ready = 1'b0;
    push_t sb[$];
    push_t mon_e;

    always #5 clk_in = ~clk_in;

    instruction_fetcher_if bus ();

    assign bus.isq_full       = isq_full_r;
    assign bus.redirect_valid = redirect_valid_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.mem_valid      = mem_valid_r;
    assign bus.mem_data       = mem_data_r;

    instruction_fetcher #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .bus      (bus)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a, input bit jal);
        if (jal && a == 32'h0) return 32'h0080_006F;
        return {a[24:0], 7'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic wait_pulse(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.instruction_ready !== 1'b1 && n < 60);
        check(tag, bus.instruction_ready, 1'b1);
    endtask

    task automatic next_req(input string tag, input logic [31:0] exp);
        int n = 0;
        while (bus.mem_req === 1'b1 && n < 40) begin tick(); n++; end
        while (bus.mem_req !== 1'b1 && n < 80) begin tick(); n++; end
        check({tag, "_req"}, bus.mem_req, 1'b1);
        check(tag, bus.mem_addr, exp);
    endtask

    // Memory stalls on the same rdy_in: only advance if the last edge was live.
    always @(posedge clk_in) prev_rdy = rdy_in;

    always @(negedge clk_in) begin
        if (bus.mem_req !== 1'b1) cnt = 0;
        if (prev_rdy) begin
            if (mem_valid_r) begin
                mem_valid_r = 1'b0;
            end else if (bus.mem_req === 1'b1) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_valid_r = 1'b1;
                    mem_data_r  = word_at(bus.mem_addr, jal_mode);
                    cnt = 0;
                end
            end
        end
    end

    // Scoreboard: every push must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (rst_n_in && bus.instruction_ready === 1'b1) begin
            pulses++;
            check("no_back_to_back", last_ready, 1'b0);
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_push: observed pc %h expected no push", bus.pc_out);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("push_instr", bus.instruction_out, mon_e.instr);
                check("push_pc", bus.pc_out, mon_e.pc);
            end
        end
        last_ready = bus.instruction_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        tick(2);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_ready", bus.instruction_ready, 1'b0);
        check("rst_instr", bus.instruction_out, 32'h0);
        check("rst_pc_out", bus.pc_out, 32'h0);
        rst_n_in = 1'b1;
        rdy_in   = 1'b1;

        // Queue full from reset: no fetch may start.
        seen = 0;
        repeat (10) begin tick(); if (bus.mem_req === 1'b1) seen++; end
        check("full_no_req", seen, 0);
        isq_full_r = 1'b0;
        sb.push_back('{32'h0000_0013, 32'h0});
        tick();
        check("first_req", bus.mem_req, 1'b1);
        check("first_addr", bus.mem_addr, 32'h0);
        wait_pulse("first_push");
        isq_full_r = 1'b1;
        check("pulses_1", pulses, 1);

        // Next fetch at 4; queue fills while in WAIT so the word parks in HOLD.
        isq_full_r = 1'b0;
        tick();
        check("second_addr", bus.mem_addr, 32'h4);
        isq_full_r = 1'b1;
        tick(8);
        check("held_no_push", pulses, 1);
        check("held_req_low", bus.mem_req, 1'b0);
        sb.push_back('{word_at(32'h4, 1'b0), 32'h4});
        isq_full_r = 1'b0;
        wait_pulse("held_push");
        isq_full_r = 1'b1;
        tick(4);
        check("pulses_2", pulses, 2);
        check("idle_req_low", bus.mem_req, 1'b0);

        // Redirect while waiting on a 3-cycle memory: stale word discarded.
        lat = 3;
        isq_full_r = 1'b0;
        tick();
        check("wait_addr", bus.mem_addr, 32'h8);
        redirect_valid_r = 1'b1;
        redirect_pc_r    = 32'h100;
        tick();
        redirect_valid_r = 1'b0;
        check("discard_req_held", bus.mem_req, 1'b1);
        check("discard_addr_held", bus.mem_addr, 32'h8);
        sb.push_back('{word_at(32'h100, 1'b0), 32'h100});
        next_req("redir_addr", 32'h100);
        wait_pulse("redir_push");
        isq_full_r = 1'b1;
        check("pulses_3", pulses, 3);

        // rdy_in low mid-WAIT: everything frozen.
        isq_full_r = 1'b0;
        tick();
        check("pause_addr", bus.mem_addr, 32'h104);
        rdy_in = 1'b0;
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104 || bus.instruction_ready !== 1'b0) seen++;
        end
        check("pause_stable", seen, 0);
        sb.push_back('{word_at(32'h104, 1'b0), 32'h104});
        rdy_in = 1'b1;
        wait_pulse("pause_push");
        isq_full_r = 1'b1;
        check("pulses_4", pulses, 4);

        // Redirect in HOLD with the queue freeing the same cycle: push suppressed.
        lat = 1;
        isq_full_r = 1'b0;
        tick();
        check("hold_addr", bus.mem_addr, 32'h108);
        isq_full_r = 1'b1;
        tick(4);
        redirect_valid_r = 1'b1;
        redirect_pc_r    = 32'h203;
        isq_full_r       = 1'b0;
        tick();
        redirect_valid_r = 1'b0;
        check("hold_redir_no_push", bus.instruction_ready, 1'b0);
        sb.push_back('{word_at(32'h200, 1'b0), 32'h200});
        next_req("hold_redir_addr", 32'h200);
        wait_pulse("hold_redir_push");
        isq_full_r = 1'b1;
        check("pulses_5", pulses, 5);

        // PC wrap at the top of the address space.
        redirect_valid_r = 1'b1;
        redirect_pc_r    = 32'hFFFF_FFFC;
        tick();
        redirect_valid_r = 1'b0;
        sb.push_back('{word_at(32'hFFFF_FFFC, 1'b0), 32'hFFFF_FFFC});
        isq_full_r = 1'b0;
        tick();
        check("top_addr", bus.mem_addr, 32'hFFFF_FFFC);
        wait_pulse("top_push");
        isq_full_r = 1'b1;
        sb.push_back('{32'h0000_0013, 32'h0});
        isq_full_r = 1'b0;
        tick();
        check("wrap_addr", bus.mem_addr, 32'h0);
        wait_pulse("wrap_push");
        isq_full_r = 1'b1;

        // JAL +8 at pc 0.
        jal_mode = 1'b1;
        redirect_valid_r = 1'b1;
        redirect_pc_r    = 32'h0;
        tick();
        redirect_valid_r = 1'b0;
        sb.push_back('{32'h0080_006F, 32'h0});
        isq_full_r = 1'b0;
        tick();
        check("jal_addr", bus.mem_addr, 32'h0);
        wait_pulse("jal_push");
        isq_full_r = 1'b1;
        sb.push_back('{word_at(JAL_NEXT, 1'b1), JAL_NEXT});
        isq_full_r = 1'b0;
        tick();
        check("jal_next_addr", bus.mem_addr, JAL_NEXT);
        wait_pulse("jal_next_push");
        isq_full_r = 1'b1;
        jal_mode = 1'b0;

        // Asynchronous reset in the middle of a fetch.
        lat = 3;
        isq_full_r = 1'b0;
        tick();
        check("pre_rst_addr", bus.mem_addr, JAL_NEXT + 32'h4);
        rst_n_in = 1'b0;
        #1;
        check("async_rst_req", bus.mem_req, 1'b0);
        check("async_rst_addr", bus.mem_addr, 32'h0);
        tick(2);
        isq_full_r = 1'b1;
        rst_n_in   = 1'b1;
        tick(5);
        check("post_rst_idle", bus.mem_req, 1'b0);
        sb.push_back('{32'h0000_0013, 32'h0});
        isq_full_r = 1'b0;
        tick();
        check("post_rst_addr", bus.mem_addr, 32'h0);
        wait_pulse("post_rst_push");
        isq_full_r = 1'b1;
        tick(3);
        check("sb_drained", sb.size(), 0);
        check("pulses_total", pulses, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
